lcd_nibble_ctrl: RTL and testbench
==================================

Name: lcd_nibble_ctrl

Overview:
Sequencing controller for the character LCD's 4-bit HD44780-style bus (lcd_rs, lcd_rw, lcd_e, lcd_4..lcd_7).
- After reset, runs the power-up and 4-bit initialisation sequence on its own.
- Then accepts byte writes (command or data) from the upstream display formatter over a valid/ready handshake.
- Splits each byte into high and low nibbles, generates setup, E-pulse and gap timing, and waits the required execution time.
- Sits between the display-content logic and the board pins.

Parameters:
SETUP_CYC, 2, cycles RS/data are stable before E rises (≥40 ns at 50 MHz)
E_PULSE_CYC, 12, E high width in cycles (≥230 ns)
NIBBLE_GAP_CYC, 50, E low time between high and low nibble (1 µs)
CMD_WAIT_CYC, 2000, post-byte wait for normal commands and data (40 µs)
CLEAR_WAIT_CYC, 82000, post-byte wait for clear/home commands (1.64 ms)
POWERUP_CYC, 750000, delay after reset before the first init nibble (15 ms)
INIT1_CYC, 205000, wait after init nibble 1 (4.1 ms)
INIT2_CYC, 5000, wait after init nibble 2 (100 µs)
CNT_W, 20, delay counter width; every *_CYC must be < 2^CNT_W

Ports:
clk  input  1  system clock, 50 MHz nominal
rst  input  1  synchronous, active-high reset
req_valid  input  1  upstream byte request
req_rs  input  1  0 = command, 1 = data
req_data  input  8  byte to write
req_ready  output  1  controller can accept a byte
init_done  output  1  initialisation complete; stays high until reset
busy  output  1  inverse of req_ready
lcd_rs  output  1  register select
lcd_rw  output  1  always 0 (write only)
lcd_e  output  1  enable strobe
lcd_4  output  1  nibble bit 0
lcd_5  output  1  nibble bit 1
lcd_6  output  1  nibble bit 2
lcd_7  output  1  nibble bit 3

Behaviour:
- All outputs are registered.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_4..7=0, req_ready=0, init_done=0, busy=1.
- States: PWRUP, INIT_NIB_SETUP, INIT_NIB_E, INIT_NIB_WAIT, SETUP_HI, E_HI, GAP, SETUP_LO, E_LO, WAIT, IDLE.
- PWRUP: count POWERUP_CYC with lcd_e=0.
- Single-nibble init (rs=0) uses SETUP → E → wait, in this order:
  - 0x3, wait INIT1_CYC
  - 0x3, wait INIT2_CYC
  - 0x3, wait CMD_WAIT_CYC
  - 0x2, wait CMD_WAIT_CYC
- Init bytes then go through the normal byte path, in order: 0x28, 0x06, 0x0C, 0x01. 0x01 uses CLEAR_WAIT_CYC.
- After the last init wait: init_done=1, enter IDLE, req_ready=1.
- Handshake:
  - A transfer occurs on a clock edge where req_valid & req_ready.
  - req_rs and req_data are captured on that edge; req_ready=0 from the next cycle.
  - req_valid while req_ready=0 is ignored. There is no queue.
- Byte path after acceptance:
  - SETUP_HI for SETUP_CYC: lcd_rs=rs, lcd_7..4=data[7:4], lcd_e=0.
  - E_HI for E_PULSE_CYC: lcd_e=1.
  - GAP for NIBBLE_GAP_CYC: lcd_e=0, high nibble held.
  - SETUP_LO for SETUP_CYC: lcd_7..4=data[3:0].
  - E_LO for E_PULSE_CYC.
  - WAIT: CLEAR_WAIT_CYC if rs=0 and data[7:2]==0 (clear or home), otherwise CMD_WAIT_CYC. Low nibble and rs are held.
  - Then IDLE with req_ready=1.
- Acceptance-to-ready latency: 2·SETUP_CYC + 2·E_PULSE_CYC + NIBBLE_GAP_CYC + wait.
- Bus values never change in the same cycle as an E edge. Data and rs change only while lcd_e=0 and at least one cycle after E falls.
- Delay counter: loads N-1 on state entry and advances at 0. Each state lasts exactly N cycles.
- Reset mid-operation: lcd_e=0 in the cycle after rst is sampled, the captured byte is dropped, and the sequence restarts at PWRUP with init_done=0.

Decomposition:
- Package lcd_ctrl_pkg holds:
  - the state enum
  - init nibble constants 0x3/0x2
  - init command constants 0x28/0x06/0x0C/0x01
  - the clear/home classification function
- Sub-module lcd_delay_timer (ports: load, load_val[CNT_W-1:0], done): a down-counter shared by all timed states.

Test Plan:
Bench parameters: SETUP=2, E=3, GAP=4, CMD_WAIT=10, CLEAR_WAIT=30, POWERUP=20, INIT1=15, INIT2=8.
- Reset release → lcd_e stays 0 for 20 cycles. Then nibbles 3,3,3,2 each with 3-cycle E pulses. Then bytes 0x28, 0x06, 0x0C, 0x01 as hi/lo nibble pairs. Then init_done=1 and req_ready=1.
- After init, send rs=1, data=0x41 → E pulses with nibble 0x4 then 0x1, rs=1, rw=0 throughout. req_ready returns exactly 24 cycles after acceptance.
- Send rs=0, data=0x01 → WAIT lasts 30 cycles, so req_ready returns 44 cycles after acceptance. rs=0, data=0x80 → 24 cycles.
- Hold req_valid high with alternating bytes during a transfer → exactly one transfer per ready window, none lost or duplicated. A scoreboard compares nibbles captured on lcd_e falling edges.
- Assert rst for 1 cycle while lcd_e=1 → lcd_e=0 on the next cycle, init_done=0, and the full init sequence repeats.
- Assertion across all tests: lcd_4..7 and lcd_rs never change in a cycle where lcd_e changes. lcd_rw is constantly 0.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780-style 4-bit LCD bus controller:
// FSM states, the fixed power-up command script and the clear/home classifier.
package lcd_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_NIB_SETUP,
        ST_INIT_NIB_E,
        ST_INIT_NIB_WAIT,
        ST_SETUP_HI,
        ST_E_HI,
        ST_GAP,
        ST_SETUP_LO,
        ST_E_LO,
        ST_WAIT,
        ST_IDLE
    } state_t;

    // Single-nibble wake-up writes issued while the panel may still be in 8-bit mode
    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;

    // Init steps 0..3 are single nibbles, 4..7 are full bytes through the byte path
    localparam logic [2:0] INIT_LAST_NIB_STEP = 3'd3;
    localparam logic [2:0] INIT_LAST_STEP     = 3'd7;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution time
    function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0);
    endfunction

    function automatic logic [3:0] init_nibble(input logic [2:0] step);
        return (step == INIT_LAST_NIB_STEP) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
    endfunction

    function automatic logic [7:0] init_byte(input logic [2:0] step);
        logic [7:0] b;
        case (step)
            3'd4:    b = CMD_FUNC_SET;
            3'd5:    b = CMD_ENTRY_MODE;
            3'd6:    b = CMD_DISPLAY_ON;
            default: b = CMD_CLEAR;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_nibble_ctrl_timer.sv
// Down-counter shared by every timed state. A load of N-1 on state entry makes
// the state last exactly N cycles; done is high while the count sits at zero.
module lcd_delay_timer #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= RST_VAL;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/lcd_nibble_ctrl.sv
// 4-bit HD44780 bus sequencer: runs the power-up/init script, then writes
// upstream bytes as two E-strobed nibbles with setup, gap and execution waits.
module lcd_nibble_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int POWERUP_CYC    = 750000,
    parameter int INIT1_CYC      = 205000,
    parameter int INIT2_CYC      = 5000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       lcd_4,
    output logic       lcd_5,
    output logic       lcd_6,
    output logic       lcd_7
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(NIBBLE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] INIT1_LD = CNT_W'(INIT1_CYC - 1);
    localparam logic [CNT_W-1:0] INIT2_LD = CNT_W'(INIT2_CYC - 1);

    state_t           state_reg;
    logic [2:0]       step_reg;
    logic [7:0]       byte_reg;
    logic             lcd_rs_reg;
    logic             lcd_e_reg;
    logic [3:0]       nibble_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             init_done_reg;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic [7:0]       next_init_byte;
    logic [3:0]       next_init_nib;

    assign next_init_byte = init_byte(step_reg + 3'd1);
    assign next_init_nib  = init_nibble(step_reg + 3'd1);

    lcd_delay_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (PWRUP_LD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // The timer is loaded with the duration of the state being entered
    always_comb begin
        tmr_load = tmr_done;
        tmr_val  = SETUP_LD;
        if (state_reg == ST_IDLE) begin
            tmr_load = req_valid && ready_reg;
        end
        case (state_reg)
            ST_INIT_NIB_SETUP, ST_SETUP_HI, ST_SETUP_LO: tmr_val = E_LD;
            ST_INIT_NIB_E: begin
                case (step_reg)
                    3'd0:    tmr_val = INIT1_LD;
                    3'd1:    tmr_val = INIT2_LD;
                    default: tmr_val = CMD_LD;
                endcase
            end
            ST_E_HI: tmr_val = GAP_LD;
            ST_E_LO: tmr_val = is_clear_home(lcd_rs_reg, byte_reg) ? CLEAR_LD : CMD_LD;
            default: tmr_val = SETUP_LD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_PWRUP;
            step_reg      <= 3'd0;
            byte_reg      <= 8'h00;
            lcd_rs_reg    <= 1'b0;
            lcd_e_reg     <= 1'b0;
            nibble_reg    <= 4'h0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b1;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_PWRUP: begin
                    if (tmr_done) begin
                        state_reg  <= ST_INIT_NIB_SETUP;
                        lcd_rs_reg <= 1'b0;
                        nibble_reg <= init_nibble(step_reg);
                    end
                end
                ST_INIT_NIB_SETUP: begin
                    if (tmr_done) begin
                        state_reg <= ST_INIT_NIB_E;
                        lcd_e_reg <= 1'b1;
                    end
                end
                ST_INIT_NIB_E: begin
                    if (tmr_done) begin
                        state_reg <= ST_INIT_NIB_WAIT;
                        lcd_e_reg <= 1'b0;
                    end
                end
                ST_INIT_NIB_WAIT: begin
                    if (tmr_done) begin
                        step_reg <= step_reg + 3'd1;
                        if (step_reg == INIT_LAST_NIB_STEP) begin
                            state_reg  <= ST_SETUP_HI;
                            byte_reg   <= next_init_byte;
                            nibble_reg <= next_init_byte[7:4];
                        end else begin
                            state_reg  <= ST_INIT_NIB_SETUP;
                            nibble_reg <= next_init_nib;
                        end
                    end
                end
                ST_SETUP_HI: begin
                    if (tmr_done) begin
                        state_reg <= ST_E_HI;
                        lcd_e_reg <= 1'b1;
                    end
                end
                ST_E_HI: begin
                    if (tmr_done) begin
                        state_reg <= ST_GAP;
                        lcd_e_reg <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (tmr_done) begin
                        state_reg  <= ST_SETUP_LO;
                        nibble_reg <= byte_reg[3:0];
                    end
                end
                ST_SETUP_LO: begin
                    if (tmr_done) begin
                        state_reg <= ST_E_LO;
                        lcd_e_reg <= 1'b1;
                    end
                end
                ST_E_LO: begin
                    if (tmr_done) begin
                        state_reg <= ST_WAIT;
                        lcd_e_reg <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (tmr_done) begin
                        if (init_done_reg || step_reg == INIT_LAST_STEP) begin
                            state_reg     <= ST_IDLE;
                            ready_reg     <= 1'b1;
                            busy_reg      <= 1'b0;
                            init_done_reg <= 1'b1;
                        end else begin
                            state_reg  <= ST_SETUP_HI;
                            step_reg   <= step_reg + 3'd1;
                            byte_reg   <= next_init_byte;
                            nibble_reg <= next_init_byte[7:4];
                        end
                    end
                end
                ST_IDLE: begin
                    if (req_valid && ready_reg) begin
                        state_reg  <= ST_SETUP_HI;
                        ready_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                        byte_reg   <= req_data;
                        lcd_rs_reg <= req_rs;
                        nibble_reg <= req_data[7:4];
                    end
                end
                default: state_reg <= ST_PWRUP;
            endcase
        end
    end

    assign req_ready = ready_reg;
    assign busy      = busy_reg;
    assign init_done = init_done_reg;
    assign lcd_rs    = lcd_rs_reg;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = lcd_e_reg;
    assign lcd_4     = nibble_reg[0];
    assign lcd_5     = nibble_reg[1];
    assign lcd_6     = nibble_reg[2];
    assign lcd_7     = nibble_reg[3];

endmodule

// File: tb/tb_lcd_nibble_ctrl.sv
// Directed bench for lcd_nibble_ctrl with shortened timing; nibbles are
// captured on every lcd_e falling edge and checked against hand-built lists.
module tb_lcd_nibble_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy;
    logic       lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic       rs;
        logic [3:0] nib;
        logic [7:0] width;
    } cap_t;

    cap_t cap_q[$];

    logic [3:0] exp_init_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                      4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

    lcd_nibble_ctrl #(
        .SETUP_CYC      (2),
        .E_PULSE_CYC    (3),
        .NIBBLE_GAP_CYC (4),
        .CMD_WAIT_CYC   (10),
        .CLEAR_WAIT_CYC (30),
        .POWERUP_CYC    (20),
        .INIT1_CYC      (15),
        .INIT2_CYC      (8),
        .CNT_W          (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .busy      (busy),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_4     (lcd_4),
        .lcd_5     (lcd_5),
        .lcd_6     (lcd_6),
        .lcd_7     (lcd_7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: E edges must never coincide with rs/data changes; log falling-edge nibbles
    logic       prev_e   = 1'b0;
    logic       prev_rs  = 1'b0;
    logic [3:0] prev_nib = 4'h0;
    int         e_width  = 0;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (lcd_e !== prev_e && {lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4} !== {prev_rs, prev_nib}) begin
                n_fail++;
                $display("FAIL bus_on_e_edge cyc=%0d: rs/nib %b/%h -> %b/%h while e %b -> %b",
                         cyc, prev_rs, prev_nib, lcd_rs, {lcd_7, lcd_6, lcd_5, lcd_4}, prev_e, lcd_e);
            end
            if (lcd_rw !== 1'b0) begin
                n_fail++;
                $display("FAIL lcd_rw cyc=%0d: got %b, need 0", cyc, lcd_rw);
            end
            if (lcd_e === 1'b1) e_width++;
            if (prev_e && !lcd_e) begin
                cap_q.push_back('{rs: prev_rs, nib: prev_nib, width: 8'(e_width)});
                e_width = 0;
            end
        end else begin
            e_width = 0;
        end
        prev_e   = lcd_e;
        prev_rs  = lcd_rs;
        prev_nib = {lcd_7, lcd_6, lcd_5, lcd_4};
    end

    task automatic send_byte(input logic rs, input logic [7:0] data,
                             output logic ready_after, output int lat);
        int a;
        lat = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        @(posedge clk); #1;
        a = cyc;
        ready_after = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (req_ready) begin
                lat = cyc - a;
                break;
            end
        end
        $display("[TB] xfer rs=%0d data=0x%02h ready_after=%0d latency=%0d", rs, data, ready_after, lat);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({lcd_e, lcd_rs, lcd_rw, lcd_7, lcd_6, lcd_5, lcd_4, req_ready, init_done, busy} !== 10'b0000000001) begin
            n_fail++;
            $display("FAIL reset_values: e rs rw d7..4 ready init busy = %b, need 0000000001",
                     {lcd_e, lcd_rs, lcd_rw, lcd_7, lcd_6, lcd_5, lcd_4, req_ready, init_done, busy});
        end
    endtask

    task automatic test_init;
        int  t0;
        int  lat;
        logic e_seen;
        @(negedge clk);
        cap_q.delete();
        rst = 1'b0;
        t0 = cyc;
        e_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (lcd_e !== 1'b0) e_seen = 1'b1;
        end
        n_tests++;
        if (e_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL powerup_quiet: lcd_e went high during first 20 cycles, need 0");
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({lcd_e, lcd_7, lcd_6, lcd_5, lcd_4} !== 5'b10011) begin
            n_fail++;
            $display("FAIL first_e_rise: e/nib=%b/%h at cycle 22, need 1/3", lcd_e, {lcd_7, lcd_6, lcd_5, lcd_4});
        end
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (init_done) begin
                lat = cyc - t0;
                break;
            end
            @(posedge clk); #1;
        end
        $display("[TB] init done after %0d cycles, %0d E pulses", lat, cap_q.size());
        n_tests++;
        if (lat !== 199) begin
            n_fail++;
            $display("FAIL init_latency: got %0d cycles, need 199", lat);
        end
        n_tests++;
        if ({req_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL init_ready: ready/busy=%b, need 10", {req_ready, busy});
        end
        n_tests++;
        if (cap_q.size() != 12) begin
            n_fail++;
            $display("FAIL init_pulse_count: got %0d, need 12", cap_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_tests++;
                if (cap_q[i] !== {1'b0, exp_init_nib[i], 8'd3}) begin
                    n_fail++;
                    $display("FAIL init_nibble[%0d]: rs/nib/width=%b/%h/%0d, need 0/%h/3",
                             i, cap_q[i].rs, cap_q[i].nib, cap_q[i].width, exp_init_nib[i]);
                end
            end
        end
    endtask

    task automatic test_data_write;
        logic ra;
        int   lat;
        cap_q.delete();
        send_byte(1'b1, 8'h41, ra, lat);
        n_tests++;
        if (ra !== 1'b0) begin
            n_fail++;
            $display("FAIL data_ready_drop: ready after accept=%b, need 0", ra);
        end
        n_tests++;
        if (lat !== 24) begin
            n_fail++;
            $display("FAIL data_latency: got %0d, need 24", lat);
        end
        n_tests++;
        if ({busy, lcd_rs} !== 2'b01) begin
            n_fail++;
            $display("FAIL data_idle_state: busy/rs=%b, need 01", {busy, lcd_rs});
        end
        n_tests++;
        if (cap_q.size() != 2) begin
            n_fail++;
            $display("FAIL data_pulse_count: got %0d, need 2", cap_q.size());
        end else begin
            n_tests++;
            if (cap_q[0] !== {1'b1, 4'h4, 8'd3} || cap_q[1] !== {1'b1, 4'h1, 8'd3}) begin
                n_fail++;
                $display("FAIL data_nibbles: got %h,%h, need 1403,1103", cap_q[0], cap_q[1]);
            end
        end
    endtask

    task automatic test_clear_home;
        logic       v_rs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] v_dat [6] = '{8'h01, 8'h80, 8'h02, 8'h03, 8'h04, 8'h01};
        int         v_lat [6] = '{44, 24, 44, 44, 24, 24};
        logic ra;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            cap_q.delete();
            send_byte(v_rs[i], v_dat[i], ra, lat);
            n_tests++;
            if (lat !== v_lat[i]) begin
                n_fail++;
                $display("FAIL wait_latency rs=%0d data=%02h: got %0d, need %0d", v_rs[i], v_dat[i], lat, v_lat[i]);
            end
            n_tests++;
            if (cap_q.size() != 2) begin
                n_fail++;
                $display("FAIL wait_pulse_count data=%02h: got %0d, need 2", v_dat[i], cap_q.size());
            end else if (cap_q[0] !== {v_rs[i], v_dat[i][7:4], 8'd3} ||
                         cap_q[1] !== {v_rs[i], v_dat[i][3:0], 8'd3}) begin
                n_fail++;
                $display("FAIL wait_nibbles data=%02h: got %h,%h", v_dat[i], cap_q[0], cap_q[1]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic       b_rs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] b_dat [4] = '{8'h48, 8'h69, 8'hC0, 8'h21};
        int   idx = 0;
        int   guard = 0;
        logic xfer;
        cap_q.delete();
        @(negedge clk);
        req_valid = 1'b1;
        while (idx < 4 && guard < 400) begin
            if (req_ready) begin
                req_rs   = b_rs[idx];
                req_data = b_dat[idx];
            end else begin
                req_rs   = guard[0];
                req_data = guard[0] ? 8'hFF : 8'h01;
            end
            xfer = req_ready;
            @(posedge clk); #1;
            if (xfer) begin
                $display("[TB] b2b accept #%0d rs=%0d data=0x%02h", idx, req_rs, req_data);
                idx++;
                n_tests++;
                if (req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready_drop: ready=%b after accept, need 0", req_ready);
                end
            end
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 60 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (idx !== 4) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d, need 4", idx);
        end
        n_tests++;
        if (cap_q.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d, need 8", cap_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (cap_q[2*i] !== {b_rs[i], b_dat[i][7:4], 8'd3} ||
                    cap_q[2*i+1] !== {b_rs[i], b_dat[i][3:0], 8'd3}) begin
                    n_fail++;
                    $display("FAIL b2b_byte[%0d]: got %h,%h, need rs=%0d data=%02h",
                             i, cap_q[2*i], cap_q[2*i+1], b_rs[i], b_dat[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int   t0;
        int   lat;
        logic ra;
        @(negedge clk);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 50 && !lcd_e; i++) @(negedge clk);
        n_tests++;
        if (lcd_e !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_e_seen: lcd_e=%b before reset, need 1", lcd_e);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({lcd_e, init_done, req_ready, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_outputs: e/init/ready/busy=%b, need 0001", {lcd_e, init_done, req_ready, busy});
        end
        @(negedge clk);
        cap_q.delete();
        rst = 1'b0;
        t0 = cyc;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (init_done) begin
                lat = cyc - t0;
                break;
            end
        end
        $display("[TB] re-init done after %0d cycles, %0d E pulses", lat, cap_q.size());
        n_tests++;
        if (lat !== 199) begin
            n_fail++;
            $display("FAIL reinit_latency: got %0d, need 199", lat);
        end
        n_tests++;
        if (cap_q.size() != 12) begin
            n_fail++;
            $display("FAIL reinit_pulse_count: got %0d, need 12", cap_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_tests++;
                if (cap_q[i] !== {1'b0, exp_init_nib[i], 8'd3}) begin
                    n_fail++;
                    $display("FAIL reinit_nibble[%0d]: got %h, need nib %h", i, cap_q[i], exp_init_nib[i]);
                end
            end
        end
        cap_q.delete();
        send_byte(1'b1, 8'h41, ra, lat);
        n_tests++;
        if (lat !== 24 || cap_q.size() != 2) begin
            n_fail++;
            $display("FAIL reinit_write: latency=%0d pulses=%0d, need 24/2", lat, cap_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_data_write();
        test_clear_home();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
